// File: rtl/data_resp_mem_if.sv
// Core data-port bus between a load/store unit and the scratchpad responder.
interface data_resp_mem_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/data_resp_mem.sv
// Scratchpad memory behind a req/gnt/rvalid data port with a programmable grant delay.
// Out-of-range accesses and empty-mask writes are granted but answered with err=1.
module data_resp_mem #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
    parameter int unsigned GNT_DELAY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    data_resp_mem_if.slave        bus,
    output logic [15:0]           access_cnt_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] DELAY = CW'(GNT_DELAY);
    localparam bit ZERO_DELAY = (GNT_DELAY == 0);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t         state;
    logic [CW-1:0]  wait_cnt;

    logic           gnt_c;
    logic           in_range_c;
    logic           err_c;
    logic [AW-1:0]  idx_c;

    logic           rvalid_q;
    logic [31:0]    rdata_q;
    logic           err_q;
    logic [15:0]    cnt_q;

    logic [31:0]    mem [MEM_WORDS];

    // Sub-word offset bits carry no meaning for a word-wide scratchpad.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.addr[1:0];

    // BASE_ADDR is aligned to the window size, so a tag compare is the range check
    // and avoids overflow when the window touches the top of the address space.
    assign in_range_c = (bus.addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign idx_c      = bus.addr[AW+1:2];
    assign err_c      = !in_range_c || (bus.we && (bus.be == 4'b0000));

    // Grant decode: combinational so a zero-delay block can grant in the request cycle.
    always_comb begin
        gnt_c = 1'b0;
        if (!rst_i && bus.req) begin
            case (state)
                S_IDLE: gnt_c = ZERO_DELAY;
                S_WAIT: gnt_c = (wait_cnt == DELAY);
                default: gnt_c = 1'b0;
            endcase
        end
    end

    assign bus.gnt = gnt_c;

    // Grant-delay FSM; a dropped request in WAIT abandons the access without a grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req && !ZERO_DELAY) begin
                        state    <= S_WAIT;
                        wait_cnt <= CW'(1);
                    end
                end
                S_WAIT: begin
                    if (!bus.req || (wait_cnt == DELAY)) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Response stage: one registered response the cycle after every grant, zeros otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rvalid_q <= gnt_c;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            if (gnt_c) begin
                cnt_q <= cnt_q + 16'd1;
                err_q <= err_c;
                if (!err_c && !bus.we) begin
                    rdata_q <= mem[idx_c];
                end
            end
        end
    end

    // Byte-masked memory write on a granted, error-free write; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (gnt_c && !err_c && bus.we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be[i]) begin
                    mem[idx_c][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.err      = err_q;
    assign access_cnt_o = cnt_q;

endmodule

// File: tb/tb_data_resp_mem.sv
// Bench for data_resp_mem: one instance with GNT_DELAY=2 and one with GNT_DELAY=0,
// directed vector table, hand sequences for multi-cycle cases, and random traffic
// against a transaction-level memory model.
module tb_data_resp_mem;

    localparam int unsigned WORDS = 256;
    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam longint unsigned BASE_L = 64'h0000_0000_0010_0000;
    localparam longint unsigned SIZE_L = 64'd1024;

    logic        clk;
    logic        rst2;
    logic        rst0;
    logic [15:0] cnt2;
    logic [15:0] cnt0;

    int checks   = 0;
    int failures = 0;

    logic [15:0] cnt_exp [3];
    logic [31:0] mref [int];

    data_resp_mem_if b2();
    data_resp_mem_if b0();

    data_resp_mem #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .GNT_DELAY(2)) dut2 (
        .clk_i        (clk),
        .rst_i        (rst2),
        .bus          (b2.slave),
        .access_cnt_o (cnt2)
    );

    data_resp_mem #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .GNT_DELAY(0)) dut0 (
        .clk_i        (clk),
        .rst_i        (rst0),
        .bus          (b0.slave),
        .access_cnt_o (cnt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        we;
        logic [31:0] off;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        if (sel == 2) begin
            b2.req = req; b2.we = we; b2.addr = addr; b2.be = be; b2.wdata = wdata;
        end else begin
            b0.req = req; b0.we = we; b0.addr = addr; b0.be = be; b0.wdata = wdata;
        end
    endtask

    function automatic logic get_gnt(input int sel);
        return (sel == 2) ? b2.gnt : b0.gnt;
    endfunction
    function automatic logic get_rvalid(input int sel);
        return (sel == 2) ? b2.rvalid : b0.rvalid;
    endfunction
    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 2) ? b2.rdata : b0.rdata;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 2) ? b2.err : b0.err;
    endfunction
    function automatic logic [15:0] get_cnt(input int sel);
        return (sel == 2) ? cnt2 : cnt0;
    endfunction

    // One request: checks grant latency (== sel, which equals the instance's delay),
    // the single response the cycle after grant, and the access counter.
    task automatic do_txn(input int sel, input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                          input bit chk_data, input string name);
        int lat;
        lat = -1;
        drive(sel, 1'b1, we, addr, be, wdata);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (get_gnt(sel)) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, "_latency"}, 32'(lat), 32'(sel));
        if (lat < 0) begin
            drive(sel, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cnt_exp[sel] = cnt_exp[sel] + 16'd1;
        @(negedge clk);
        check({name, "_rvalid"}, 32'(get_rvalid(sel)), 32'h1);
        check({name, "_err"}, 32'(get_err(sel)), 32'(exp_err));
        if (chk_data) check({name, "_rdata"}, get_rdata(sel), exp_rdata);
        check({name, "_cnt"}, 32'(get_cnt(sel)), 32'(cnt_exp[sel]));
        check({name, "_gnt_idle"}, 32'(get_gnt(sel)), 32'h0);
        @(posedge clk); #1;
    endtask

    // Reference: decode, error rules and byte merging computed directly from the address map.
    task automatic model_txn(input int sel, input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input string name);
        longint unsigned a;
        bit          in_rng;
        int          key;
        logic [31:0] cur;
        logic [31:0] er;
        logic        ee;
        bit          chk;
        a      = {32'h0, addr};
        in_rng = (a >= BASE_L) && (a < BASE_L + SIZE_L);
        er  = 32'h0;
        ee  = 1'b0;
        chk = 1'b1;
        if (!in_rng || (we && be == 4'b0000)) begin
            ee = 1'b1;
        end else begin
            key = sel * 4096 + int'((a - BASE_L) / 4);
            if (we) begin
                cur = mref.exists(key) ? mref[key] : 32'h0;
                for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wdata[8*i +: 8];
                mref[key] = cur;
            end else if (mref.exists(key)) begin
                er = mref[key];
            end else begin
                chk = 1'b0;
            end
        end
        do_txn(sel, we, addr, be, wdata, er, ee, chk, name);
    endtask

    task automatic random_phase(input int sel);
        logic [31:0] addr;
        int r;
        for (int w = 0; w < 16; w++) model_txn(sel, 1'b1, BASE + 32'(4 * w), 4'hF, $urandom, "fill");
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            else if (r == 8) addr = BASE + 32'h400 + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(0, 3));
            else             addr = BASE - 32'd4 - 32'(4 * $urandom_range(0, 255));
            model_txn(sel, 1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom, "rand");
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h008, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h008, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h00C, 4'hF, 32'h11223344, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h00C, 4'h5, 32'hAABBCCDD, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h00C, 4'h0, 32'h0,        32'h11BB33DD, 1'b0};
        tbl[5]  = '{1'b0, 32'h400, 4'hF, 32'h0,        32'h0,        1'b1};
        tbl[6]  = '{1'b1, 32'h008, 4'h0, 32'h12345678, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 32'h008, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[8]  = '{1'b0, 32'h00E, 4'hF, 32'h0,        32'h11BB33DD, 1'b0};
        tbl[9]  = '{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,   32'h0,        1'b1};
        tbl[10] = '{1'b1, 32'h3FC, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'h3FF, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[12] = '{1'b1, 32'h000, 4'hF, 32'h01020304, 32'h0,        1'b0};
        tbl[13] = '{1'b1, 32'h400, 4'hF, 32'h55555555, 32'h0,        1'b1};
        tbl[14] = '{1'b0, 32'h000, 4'hF, 32'h0,        32'h01020304, 1'b0};

        cnt_exp[0] = 16'h0;
        cnt_exp[1] = 16'h0;
        cnt_exp[2] = 16'h0;

        // Reset, with a pending request on the zero-delay instance that must not be granted.
        rst2 = 1'b1;
        rst0 = 1'b1;
        drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(0, 1'b1, 1'b0, BASE, 4'hF, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt0_forced", 32'(b0.gnt), 32'h0);
        check("rst_gnt2", 32'(b2.gnt), 32'h0);
        @(posedge clk); #1;
        rst2 = 1'b0;
        rst0 = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        for (int s = 0; s <= 2; s += 2) begin
            check("rst_rvalid", 32'(get_rvalid(s)), 32'h0);
            check("rst_rdata", get_rdata(s), 32'h0);
            check("rst_err", 32'(get_err(s)), 32'h0);
            check("rst_cnt", 32'(get_cnt(s)), 32'h0);
        end
        @(posedge clk); #1;

        // Directed vectors on the GNT_DELAY=2 instance.
        for (int i = 0; i < 15; i++) begin
            do_txn(2, tbl[i].we, BASE + tbl[i].off, tbl[i].be, tbl[i].wdata,
                   tbl[i].exp_rdata, tbl[i].exp_err, 1'b1, "vec");
        end

        // Request withdrawn while waiting: no grant, no response, counter unchanged.
        drive(2, 1'b1, 1'b0, BASE, 4'hF, 32'h0);
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("drop_gnt", 32'(b2.gnt), 32'h0);
            check("drop_rvalid", 32'(b2.rvalid), 32'h0);
            @(posedge clk); #1;
        end
        check("drop_cnt", 32'(cnt2), 32'(cnt_exp[2]));

        // Reset while waiting for grant discards the request and clears the counter.
        drive(2, 1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
        @(posedge clk); #1;
        rst2 = 1'b1;
        @(negedge clk);
        check("rstw_gnt", 32'(b2.gnt), 32'h0);
        @(posedge clk); #1;
        rst2 = 1'b0;
        drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cnt_exp[2] = 16'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rstw_gnt_after", 32'(b2.gnt), 32'h0);
            check("rstw_rvalid_after", 32'(b2.rvalid), 32'h0);
            @(posedge clk); #1;
        end
        check("rstw_cnt", 32'(cnt2), 32'h0);
        do_txn(2, 1'b0, BASE + 32'h8, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "rstw_next");

        // Random traffic on both instances.
        random_phase(2);
        random_phase(0);

        // Zero-delay streaming: four reads with req held high.
        drive(0, 1'b1, 1'b0, BASE, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stream_gnt", 32'(b0.gnt), 32'h1);
            if (i > 0) begin
                check("stream_rvalid", 32'(b0.rvalid), 32'h1);
                check("stream_rdata", b0.rdata, mref[i - 1]);
            end
            @(posedge clk); #1;
            if (i < 3) drive(0, 1'b1, 1'b0, BASE + 32'(4 * (i + 1)), 4'hF, 32'h0);
            else       drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        @(negedge clk);
        check("stream_rvalid_last", 32'(b0.rvalid), 32'h1);
        check("stream_rdata_last", b0.rdata, mref[3]);
        check("stream_gnt_end", 32'(b0.gnt), 32'h0);
        cnt_exp[0] = cnt_exp[0] + 16'd4;
        check("stream_cnt", 32'(cnt0), 32'(cnt_exp[0]));
        @(posedge clk); #1;
        @(negedge clk);
        check("stream_rvalid_off", 32'(b0.rvalid), 32'h0);
        check("stream_rdata_off", b0.rdata, 32'h0);
        @(posedge clk); #1;

        // Counter wrap: 65535 grants from reset, then one more.
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        cnt_exp[0] = 16'h0;
        @(negedge clk);
        check("wrap_rst_cnt", 32'(cnt0), 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, BASE, 4'hF, 32'h0);
        repeat (65535) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("wrap_cnt_ffff", 32'(cnt0), 32'h0000FFFF);
        check("wrap_rvalid", 32'(b0.rvalid), 32'h1);
        @(posedge clk); #1;
        cnt_exp[0] = 16'hFFFF;
        model_txn(0, 1'b0, BASE + 32'h4, 4'hF, 32'h0, "wrap_last");
        check("wrap_cnt_zero", 32'(cnt0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
